// File: rtl/wb_bram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_bram_pkg
// Description : Shared Wishbone cycle/burst type codes and controller states
//               for the burst-capable BRAM controller and its address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_bram_pkg;

  localparam logic [2:0] c_cti_classic = 3'b000;
  localparam logic [2:0] c_cti_const   = 3'b001;
  localparam logic [2:0] c_cti_incr    = 3'b010;
  localparam logic [2:0] c_cti_ni_rsvd = 3'b100;
  localparam logic [2:0] c_cti_end     = 3'b111;

  localparam logic [1:0] c_bte_linear       = 2'b00;
  localparam logic [1:0] c_bte_four_beat    = 2'b01;
  localparam logic [1:0] c_bte_eight_beat   = 2'b10;
  localparam logic [1:0] c_bte_sixteen_beat = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_BURST  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : wb_burst_addr_gen
// Description : Combinational next-beat word address for Wishbone linear and
//               wrapping (4/8/16) bursts; upper bits hold on wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_burst_addr_gen
  import wb_bram_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic [AW-1:0] i_addr,
  input  logic [1:0]    i_bte,
  output logic [AW-1:0] o_next
);

  logic [AW-1:0] w_mask;
  logic [AW-1:0] w_inc;

  always_comb begin
    w_inc = i_addr + AW'(1);
    case (i_bte)
      c_bte_four_beat:    w_mask = AW'(4'h3);
      c_bte_eight_beat:   w_mask = AW'(4'h7);
      c_bte_sixteen_beat: w_mask = AW'(4'hF);
      c_bte_linear:       w_mask = '1;
      default:            w_mask = '1;
    endcase
    // only the masked low bits take the incremented value
    o_next = (i_addr & ~w_mask) | (w_inc & w_mask);
  end

endmodule
`default_nettype wire

// File: rtl/wb_bram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_bram_burst_ctrl
// Description : Wishbone B4 slave for a byte-enabled single-port BRAM with
//               1-cycle read latency; classic and pipelined burst cycles.
//               Optional range check: define WB_BRAM_ADDR_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bram_burst_ctrl
  import wb_bram_pkg::*;
#(
  parameter int    Dw         = 32,
  parameter int    Aw         = 10,
  parameter int    SELw       = Dw / 8,
  parameter int    CTIw       = 3,
  parameter int    BTEw       = 2,
  parameter string BURST_MODE = "ENABLED",
  parameter int    MEM_WORDS  = 2 ** Aw
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Dw-1:0]   sa_dat_i,
  input  logic [SELw-1:0] sa_sel_i,
  input  logic [Aw-1:0]   sa_addr_i,
  input  logic [CTIw-1:0] sa_cti_i,
  input  logic [BTEw-1:0] sa_bte_i,
  input  logic            sa_stb_i,
  input  logic            sa_cyc_i,
  input  logic            sa_we_i,
  output logic [Dw-1:0]   sa_dat_o,
  output logic            sa_ack_o,
  output logic            sa_err_o,
  output logic            sa_rty_o,
  output logic [Dw-1:0]   d,
  output logic [Aw-1:0]   addr,
  output logic            we,
  output logic [SELw-1:0] byteena_a,
  input  logic [Dw-1:0]   q
);

  localparam bit c_burst_en = (BURST_MODE == "ENABLED");

  state_t        r_state, w_state_nxt;
  logic          r_ack, w_ack_nxt;
  logic          r_err, w_err_nxt;
  logic [Aw-1:0] r_cnt, w_cnt_nxt;
  logic [Aw-1:0] r_cur, w_cur_nxt;
  logic [Aw-1:0] w_gen_in, w_gen_out;
  logic [Aw-1:0] w_addr, w_chk_addr;
  logic          w_we, w_req, w_beat, w_is_end, w_is_burst, w_chk_ok;

  assign w_req    = sa_cyc_i & sa_stb_i & ~sa_ack_o & ~sa_err_o;
  assign w_beat   = sa_cyc_i & sa_stb_i;
  assign w_is_end = (sa_cti_i == CTIw'(c_cti_end));

  always_comb begin
    w_is_burst = 1'b0;
    case (sa_cti_i)
      CTIw'(c_cti_incr): w_is_burst = c_burst_en;
      CTIw'(c_cti_classic), CTIw'(c_cti_const),
      CTIw'(c_cti_ni_rsvd), CTIw'(c_cti_end): w_is_burst = 1'b0;
      default:           w_is_burst = 1'b0;
    endcase
  end

  assign w_gen_in = (r_state == ST_IDLE) ? sa_addr_i : r_cnt;

  wb_burst_addr_gen #(
    .AW (Aw)
  ) u_addr_gen (
    .i_addr (w_gen_in),
    .i_bte  (sa_bte_i[1:0]),
    .o_next (w_gen_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_cur   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cur   <= w_cur_nxt;
    end
  end

  // r_cur is the beat whose data sits on q; r_cnt is the beat after it
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur;
    w_addr      = sa_addr_i;
    w_chk_addr  = sa_addr_i;
    w_we        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_cur_nxt = sa_addr_i;
          if (!w_chk_ok) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_SINGLE;
          end else begin
            w_we      = sa_we_i;
            w_ack_nxt = 1'b1;
            if (w_is_burst) begin
              w_state_nxt = ST_BURST;
              w_cnt_nxt   = w_gen_out;
            end else begin
              w_state_nxt = ST_SINGLE;
            end
          end
        end
      end
      ST_SINGLE: begin
        w_state_nxt = ST_IDLE;
      end
      ST_BURST: begin
        if (!sa_cyc_i) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_beat) begin
          // paused: keep the pending beat's data on q and resume in place
          w_ack_nxt = r_ack;
          w_addr    = r_cur;
        end else if (w_is_end) begin
          w_we        = sa_we_i;
          w_state_nxt = ST_IDLE;
        end else begin
          w_we       = sa_we_i;
          w_addr     = sa_we_i ? sa_addr_i : r_cnt;
          w_chk_addr = r_cnt;
          if (w_chk_ok) begin
            w_ack_nxt = 1'b1;
            w_cur_nxt = r_cnt;
            w_cnt_nxt = w_gen_out;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef WB_BRAM_ADDR_CHECK_EN
  localparam logic [Aw:0] c_mem_words = (Aw + 1)'(MEM_WORDS);
  assign w_chk_ok = ({1'b0, w_chk_addr} < c_mem_words);
  assign sa_err_o = r_err & sa_cyc_i & sa_stb_i;
`else
  logic w_unused_chk;
  assign w_chk_ok     = 1'b1;
  assign sa_err_o     = 1'b0;
  assign w_unused_chk = ^{w_chk_addr, r_err, (Aw + 1)'(MEM_WORDS)};
`endif

  // ack is qualified by the live strobe so a paused burst sees no stray ack
  assign sa_ack_o  = r_ack & sa_cyc_i & sa_stb_i;
  assign sa_rty_o  = 1'b0;
  assign sa_dat_o  = q;
  assign d         = sa_dat_i;
  assign addr      = w_addr;
  assign we        = w_we & reset;
  assign byteena_a = sa_we_i ? sa_sel_i : {SELw{1'b1}};

endmodule
`default_nettype wire

// File: doc/wb_bram_burst_ctrl.md
Name: wb_bram_burst_ctrl

Overview:
Wishbone B4 slave controller for a single-port, byte-enabled block RAM with 1-cycle read latency. It generalises the team's BRAM controller:
- any data width that is a multiple of 8
- native byte enables, so no read-modify-write
- pipelined incrementing and wrapping bursts at one beat per clock
- optional out-of-range error response

It sits between the NoC/CPU Wishbone interconnect and a ProNoC RAM instance.

Parameters:
- Dw, 32: data width in bits; must be a multiple of 8, 8..512.
- Aw, 10: word address width.
- SELw, Dw/8: byte-select width.
- CTIw, 3: cycle type identifier width.
- BTEw, 2: burst type extension width.
- BURST_MODE, "ENABLED": "ENABLED" or "DISABLED". When "DISABLED", every access is a classic single cycle.
- MEM_WORDS, 2**Aw: number of implemented words; only used with WB_BRAM_ADDR_CHECK_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- sa_dat_i  in  Dw  write data.
- sa_sel_i  in  SELw  byte selects.
- sa_addr_i  in  Aw  word address.
- sa_cti_i  in  CTIw  cycle type.
- sa_bte_i  in  BTEw  burst type.
- sa_stb_i  in  1  strobe.
- sa_cyc_i  in  1  cycle.
- sa_we_i  in  1  write enable.
- sa_dat_o  out  Dw  read data; equals q.
- sa_ack_o  out  1  registered acknowledge.
- sa_err_o  out  1  registered error.
- sa_rty_o  out  1  retry; constant 0.
- d  out  Dw  BRAM write data; equals sa_dat_i.
- addr  out  Aw  BRAM address.
- we  out  1  BRAM write enable.
- byteena_a  out  SELw  BRAM byte enables; equals sa_sel_i on writes, all ones on reads.
- q  in  Dw  BRAM read data.

Behaviour:
- Reset (reset=0, async): state=IDLE, sa_ack_o=0, sa_err_o=0, burst address counter=0.
- we is gated to 0 while reset is low. Reset mid-burst aborts with no further ack.
- req = sa_cyc_i & sa_stb_i & ~sa_ack_o & ~sa_err_o.
- States: IDLE, SINGLE, BURST.

IDLE:
- On req, addr=sa_addr_i and we=sa_we_i.
- If cti is 000, 111 or 100 (100 is treated as classic), or BURST_MODE="DISABLED": go to SINGLE; ack is 1 in the next cycle.
- If cti=010 and bursts are enabled: go to BURST; ack is 1 next cycle; counter=next(sa_addr_i).
- cti 001 and 011 are treated as classic.

SINGLE:
- Ack is high for exactly one cycle, with read data valid alongside it; then go to IDLE.
- Read latency is 1 wait state: request at cycle N, ack plus data at N+1.

BURST:
- Ack stays high every cycle while cyc&stb are high.
- Reads: addr=counter (prefetch of the next beat); counter advances each acked cycle.
- Writes: addr=sa_addr_i and data=sa_dat_i every acked cycle. A beat written twice is idempotent.
- cti=111 while ack is high: ack drops next cycle, go to IDLE.
- stb=0 with cyc=1: ack drops, counter holds, the burst resumes at the same beat.
- cyc=0: go to IDLE immediately; ack is 0 next cycle.

next(a) for word-granular addresses:
- BTE 00: a+1, modulo 2**Aw.
- BTE 01: wraps the low 2 bits.
- BTE 10: wraps the low 3 bits.
- BTE 11: wraps the low 4 bits.
- The upper bits are unchanged.

sa_err_o and sa_ack_o are never both 1.

Optional Feature:
WB_BRAM_ADDR_CHECK_EN
- Defined: any beat with address >= MEM_WORDS returns sa_err_o (1 cycle, same timing as ack) instead of ack.
  - we is forced 0 for that beat.
  - An error in BURST terminates the burst and returns to IDLE.
- Undefined: no range check; sa_err_o is tied to 0 and addresses use the low Aw bits only.

Decomposition:
- Package wb_bram_pkg holds:
  - CTI constants: CLASSIC=000, CONST=001, INCR=010, NI_RSVD=100, END=111.
  - BTE constants: LINEAR, FOUR_BEAT, EIGHT_BEAT, SIXTEEN_BEAT.
  - The state encoding.
- Sub-module wb_burst_addr_gen: combinational next(a, bte) for parametrised Aw, reused by the DMA engines.

Test Plan:
- Single write, then single read: write 0xDEADBEEF with sel=1111 to addr 5, read addr 5 → ack one cycle after stb each time; read returns 0xDEADBEEF.
- Byte-enable write: write 0x11223344 with sel=0010 over 0xDEADBEEF → memory holds 0xDEAD33EF.
- Linear read burst: 8 beats from addr 0x3FE with Aw=10, cti=010 then 111 on the last beat → 8 consecutive acks with no bubbles; data from 0x3FE, 0x3FF, 0x000, …
- Wrap-4 burst: read from addr 6 with BTE=01 → addresses 6, 7, 4, 5; ack drops the cycle after the cti=111 beat.
- Mid-burst events: stb low for 2 cycles in a burst → ack low for those cycles and no address skip. Async reset mid-burst → ack=0 immediately and we=0.
- With WB_BRAM_ADDR_CHECK_EN and MEM_WORDS=768: write to 800 → err=1, ack=0, memory unchanged. Read from 700 → ack.
